// File: rtl/alu_uart_ctrl_if.sv
// UART FIFO handshake bundle between the ALU controller (master) and the RX/TX FIFOs (slave).
interface alu_uart_ctrl_if #(
  parameter int unsigned size = 8
);
  logic            rx_empty;
  logic [size-1:0] r_data;
  logic            rd_uart;
  logic            tx_full;
  logic [size-1:0] w_data;
  logic            wr_uart;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, w_data, wr_uart
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, w_data, wr_uart
  );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, OP bytes from the UART RX FIFO, runs them through an external ALU
// and pushes the result byte to the TX FIFO; aborts a stalled frame after TIMEOUT cycles.
module alu_uart_ctrl #(
  parameter int unsigned size    = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                clk,
  input  logic                reset,
  alu_uart_ctrl_if.master     uart,
  output logic [size-1:0]     alu_a,
  output logic [size-1:0]     alu_b,
  output logic [5:0]          alu_op,
  input  logic [size-1:0]     alu_res,
  output logic [size-1:0]     leds,
  output logic                err,
  output logic [7:0]          op_count
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    RX_A,
    RX_B,
    RX_OP,
    EXEC,
    TX
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [size-1:0]  result;
  logic             pop, push, tmo_hit;

  // Next state, FIFO strobes and idle-timeout bookkeeping.
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = '0;
    pop         = 1'b0;
    push        = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      RX_A: begin
        if (!uart.rx_empty) begin
          pop       = 1'b1;
          state_nxt = RX_B;
        end
      end
      RX_B, RX_OP: begin
        // An arriving byte takes priority over an expiring timeout.
        if (!uart.rx_empty) begin
          pop       = 1'b1;
          state_nxt = (state == RX_B) ? RX_OP : EXEC;
        end else if (tmo_cnt == CNT_W'(TIMEOUT - 2)) begin
          tmo_hit   = 1'b1;
          state_nxt = RX_A;
        end else begin
          tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
        end
      end
      EXEC: state_nxt = TX;
      TX: begin
        if (!uart.tx_full) begin
          push      = 1'b1;
          state_nxt = RX_A;
        end
      end
      default: state_nxt = RX_A;
    endcase
    // No FIFO traffic while reset is held.
    if (reset) begin
      pop  = 1'b0;
      push = 1'b0;
    end
  end

  // State, operand, result and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RX_A;
      tmo_cnt  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      result   <= '0;
      op_count <= '0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      err     <= tmo_hit;
      if (pop) begin
        case (state)
          RX_A:    alu_a  <= uart.r_data;
          RX_B:    alu_b  <= uart.r_data;
          RX_OP:   alu_op <= uart.r_data[5:0];
          default: ;
        endcase
      end
      if (state == EXEC) result <= alu_res;
      if (push) op_count <= op_count + 8'd1;
    end
  end

  assign uart.rd_uart = pop;
  assign uart.wr_uart = push;
  assign uart.w_data  = result;
  assign leds         = result;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: table of ALU frames plus hand-written
// back-pressure, timeout, mid-frame reset and op_count wrap sequences.
module tb_alu_uart_ctrl;

  localparam int unsigned SIZE = 8;
  localparam int unsigned TMO  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_a, alu_b, alu_res, leds, op_count;
  logic [5:0] alu_op;
  logic       err;

  always #5 clk = ~clk;

  alu_uart_ctrl_if #(.size(SIZE)) uart ();

  alu_uart_ctrl #(.size(SIZE), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .uart     (uart),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .leds     (leds),
    .err      (err),
    .op_count (op_count)
  );

  // Reference ALU (MIPS funct-style opcodes), unknown ops yield all ones.
  always_comb begin
    case (alu_op)
      6'h00:   alu_res = alu_a << alu_b[2:0];
      6'h02:   alu_res = alu_a >> alu_b[2:0];
      6'h03:   alu_res = 8'($signed(alu_a) >>> alu_b[2:0]);
      6'h20:   alu_res = alu_a + alu_b;
      6'h22:   alu_res = alu_a - alu_b;
      6'h24:   alu_res = alu_a & alu_b;
      6'h25:   alu_res = alu_a | alu_b;
      6'h26:   alu_res = alu_a ^ alu_b;
      6'h27:   alu_res = ~(alu_a | alu_b);
      6'h2A:   alu_res = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
      default: alu_res = 8'hFF;
    endcase
  end

  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int err_cnt = 0;

  always @(posedge clk) begin
    if (uart.rd_uart === 1'b1) rd_cnt++;
    if (uart.wr_uart === 1'b1) wr_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_ops = 8'd0;
  logic [7:0] exp_res = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    uart.rx_empty = 1'b0;
    uart.r_data   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uart.rx_empty = 1'b1;
    end
  endtask

  // One full frame with tx_full low; optional idle gap between A and B.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] res, input int gap, input bit verbose);
    int rd0, wr0, er0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    er0 = err_cnt;
    push_byte(a);
    idle(gap);
    push_byte(b);
    push_byte(op);
    @(negedge clk);
    uart.rx_empty = 1'b1;
    #1;
    if (verbose) chk("exec_no_wr", 32'(uart.wr_uart), 32'd0);
    @(negedge clk);
    #1;
    if (verbose) begin
      chk("tx_wr_uart", 32'(uart.wr_uart), 32'd1);
      chk("tx_w_data", 32'(uart.w_data), 32'(res));
    end
    @(negedge clk);
    #1;
    exp_ops = exp_ops + 8'd1;
    exp_res = res;
    if (verbose) begin
      chk("rd_pops", 32'(rd_cnt - rd0), 32'd3);
      chk("wr_pulses", 32'(wr_cnt - wr0), 32'd1);
      chk("no_err", 32'(err_cnt - er0), 32'd0);
      chk("leds", 32'(leds), 32'(res));
      chk("op_count", 32'(op_count), 32'(exp_ops));
      chk("alu_a", 32'(alu_a), 32'(a));
      chk("alu_b", 32'(alu_b), 32'(b));
      chk("alu_op", 32'(alu_op), 32'(op[5:0]));
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, er0, bad;
    logic [7:0] hold;

    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08};
    vecs[1]  = '{8'h80, 8'h01, 8'h03, 8'hC0};
    vecs[2]  = '{8'h12, 8'h34, 8'h3F, 8'hFF};
    vecs[3]  = '{8'h0A, 8'h03, 8'h22, 8'h07};
    vecs[4]  = '{8'hF0, 8'h3C, 8'h24, 8'h30};
    vecs[5]  = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
    vecs[6]  = '{8'hFF, 8'h0F, 8'h26, 8'hF0};
    vecs[7]  = '{8'h00, 8'h00, 8'h27, 8'hFF};
    vecs[8]  = '{8'h01, 8'h05, 8'h00, 8'h20};
    vecs[9]  = '{8'h80, 8'h03, 8'h02, 8'h10};
    vecs[10] = '{8'h03, 8'h05, 8'h2A, 8'h01};
    vecs[11] = '{8'h80, 8'h01, 8'h2A, 8'h01};
    vecs[12] = '{8'h05, 8'h03, 8'hE0, 8'h08};
    vecs[13] = '{8'h7F, 8'h80, 8'h2A, 8'h00};

    // Reset with a byte waiting: nothing may be popped.
    reset         = 1'b1;
    uart.rx_empty = 1'b0;
    uart.r_data   = 8'hAA;
    uart.tx_full  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_uart", 32'(uart.rd_uart), 32'd0);
    chk("rst_wr_uart", 32'(uart.wr_uart), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_w_data", 32'(uart.w_data), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_no_pop", 32'(rd_cnt), 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    uart.rx_empty = 1'b1;

    for (int i = 0; i < 14; i++)
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, 0, 1'b1);

    // Back-pressure: TX held full well past the timeout length.
    uart.tx_full = 1'b1;
    wr0 = wr_cnt;
    er0 = err_cnt;
    push_byte(8'h09);
    push_byte(8'h04);
    push_byte(8'h22);
    @(negedge clk);
    uart.rx_empty = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (uart.wr_uart !== 1'b0 || uart.w_data !== 8'h05) bad++;
    end
    chk("full_stall_cycles_bad", 32'(bad), 32'd0);
    chk("full_no_err", 32'(err_cnt - er0), 32'd0);
    @(negedge clk);
    uart.tx_full = 1'b0;
    #1;
    chk("full_release_wr", 32'(uart.wr_uart), 32'd1);
    @(negedge clk);
    #1;
    exp_ops = exp_ops + 8'd1;
    exp_res = 8'h05;
    chk("full_single_pulse", 32'(wr_cnt - wr0), 32'd1);
    @(negedge clk);
    #1;
    chk("full_no_extra_pulse", 32'(wr_cnt - wr0), 32'd1);
    chk("full_op_count", 32'(op_count), 32'(exp_ops));

    // Timeout: A only, then RX starves.
    er0 = err_cnt;
    rd0 = rd_cnt;
    bad = 0;
    push_byte(8'h07);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      uart.rx_empty = 1'b1;
      #1;
      if (k <= 15 && err !== 1'b0) bad++;
      if (k == 16) chk("tmo_err_pulse", 32'(err), 32'd1);
      if (k == 17) chk("tmo_err_one_cycle", 32'(err), 32'd0);
    end
    chk("tmo_early_err", 32'(bad), 32'd0);
    chk("tmo_err_count", 32'(err_cnt - er0), 32'd1);
    chk("tmo_pops", 32'(rd_cnt - rd0), 32'd1);
    chk("tmo_alu_a", 32'(alu_a), 32'h07);
    chk("tmo_leds_kept", 32'(leds), 32'(exp_res));
    run_frame(8'h02, 8'h02, 8'h20, 8'h04, 0, 1'b1);

    // Byte arrives in the very cycle the timeout would expire.
    run_frame(8'h11, 8'h22, 8'h20, 8'h33, int'(TMO) - 2, 1'b1);

    // Long idle in RX_A never times out.
    er0 = err_cnt;
    idle(40);
    #1;
    chk("rx_a_idle_no_err", 32'(err_cnt - er0), 32'd0);

    // Reset in RX_OP discards the partial frame.
    push_byte(8'h33);
    push_byte(8'h44);
    @(negedge clk);
    rd0           = rd_cnt;
    wr0           = wr_cnt;
    reset         = 1'b1;
    uart.r_data   = 8'h55;
    uart.rx_empty = 1'b0;
    #1;
    chk("midrst_rd_uart", 32'(uart.rd_uart), 32'd0);
    chk("midrst_wr_uart", 32'(uart.wr_uart), 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    uart.rx_empty = 1'b1;
    #1;
    exp_ops = 8'd0;
    exp_res = 8'd0;
    chk("midrst_no_pop", 32'(rd_cnt - rd0), 32'd0);
    chk("midrst_no_wr", 32'(wr_cnt - wr0), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    chk("midrst_alu_b", 32'(alu_b), 32'd0);
    chk("midrst_alu_op", 32'(alu_op), 32'd0);
    chk("midrst_leds", 32'(leds), 32'd0);
    chk("midrst_op_count", 32'(op_count), 32'd0);
    run_frame(8'hFF, 8'h01, 8'h20, 8'h00, 0, 1'b1);

    // op_count wrap after 256 frames since reset.
    for (int i = 0; i < 254; i++) begin
      hold = 8'(i);
      run_frame(hold, 8'h01, 8'h20, hold + 8'h01, 0, 1'b0);
    end
    chk("wrap_at_255", 32'(op_count), 32'(exp_ops));
    chk("wrap_last_w_data", 32'(uart.w_data), 32'h00 + 32'd254);
    run_frame(8'h10, 8'h20, 8'h25, 8'h30, 0, 1'b0);
    chk("wrap_to_zero", 32'(op_count), 32'd0);
    chk("wrap_exp_zero", 32'(exp_ops), 32'(op_count));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
